// File: rtl/gfx_cmd_queue_if.sv
// CPU staging/commit port, status, and graphics-processor register write port
// of the command queue.
interface gfx_cmd_queue_if;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [31:0] wr_data;
    logic [31:0] status_out;
    logic [31:0] ctrl_out;
    logic [31:0] tl_out;
    logic [31:0] br_out;
    logic [31:0] arg_out;
    logic        ctrl_we;
    logic        tl_we;
    logic        br_we;
    logic        arg_we;
    logic        gp_finish;

    modport master (
        output wr_en, wr_sel, wr_data, gp_finish,
        input  status_out, ctrl_out, tl_out, br_out, arg_out,
        input  ctrl_we, tl_we, br_we, arg_we
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, gp_finish,
        output status_out, ctrl_out, tl_out, br_out, arg_out,
        output ctrl_we, tl_we, br_we, arg_we
    );
endinterface

// File: rtl/gfx_cmd_queue.sv
// Command FIFO plus dispatcher that drives the graphics processor's register
// ports in disarm/load/arm/wait/release order, one command at a time.
module gfx_cmd_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    gfx_cmd_queue_if.slave  bus
);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOAD, S_ARM, S_WAIT, S_REL} state_t;

    typedef struct packed {
        logic        op;
        logic [18:0] tl;
        logic [18:0] br;
        logic [11:0] arg;
    } cmd_t;

    state_t            state, next;
    cmd_t              mem [DEPTH];
    cmd_t              head;
    logic [18:0]       stg_tl, stg_br;
    logic [11:0]       stg_arg;
    logic [ADDR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [15:0]       done_count;
    logic              cur_op;
    logic [31:0]       ctrl_r, tl_r, br_r, arg_r;
    logic              cmd_wr, push_req, flush, full, empty, do_push, pop, busy;
    logic              unused_bits;

    assign cmd_wr   = bus.wr_en && (bus.wr_sel == 2'd3);
    assign push_req = cmd_wr && !bus.wr_data[31];
    assign flush    = cmd_wr && bus.wr_data[31];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // Fullness uses the pre-edge count: a same-cycle pop does not make room.
    assign do_push  = push_req && !full;
    assign head     = mem[rptr];
    assign busy     = (state != S_IDLE) || !empty;

    assign unused_bits = ^{bus.wr_data[30:26], bus.wr_data[15:12]};

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_tl  <= '0;
            stg_br  <= '0;
            stg_arg <= '0;
        end else if (bus.wr_en) begin
            case (bus.wr_sel)
                2'd0:    stg_tl  <= {bus.wr_data[25:16], bus.wr_data[8:0]};
                2'd1:    stg_br  <= {bus.wr_data[25:16], bus.wr_data[8:0]};
                2'd2:    stg_arg <= bus.wr_data[11:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wptr] <= '{op: bus.wr_data[0], tl: stg_tl, br: stg_br, arg: stg_arg};
    end

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_req && full) overflow <= 1'b1;
            if (do_push) wptr <= wptr + ADDR_W'(1);
            if (pop)     rptr <= rptr + ADDR_W'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_INIT;
        else     state <= next;
    end

    always_comb begin
        next        = state;
        pop         = 1'b0;
        bus.ctrl_we = 1'b0;
        bus.tl_we   = 1'b0;
        bus.br_we   = 1'b0;
        bus.arg_we  = 1'b0;
        case (state)
            S_INIT: begin
                bus.ctrl_we = 1'b1;
                next        = S_IDLE;
            end
            S_IDLE: if (!empty) begin
                pop  = 1'b1;
                next = S_LOAD;
            end
            S_LOAD: begin
                bus.tl_we  = 1'b1;
                bus.br_we  = 1'b1;
                bus.arg_we = 1'b1;
                next       = S_ARM;
            end
            S_ARM: begin
                bus.ctrl_we = 1'b1;
                next        = S_WAIT;
            end
            S_WAIT: if (bus.gp_finish) next = S_REL;
            S_REL: begin
                bus.ctrl_we = 1'b1;
                next        = S_IDLE;
            end
            default: next = S_INIT;
        endcase
    end

    // Output data is loaded on the edge entering the state that pulses it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_op     <= 1'b0;
            ctrl_r     <= '0;
            tl_r       <= '0;
            br_r       <= '0;
            arg_r      <= '0;
            done_count <= '0;
        end else begin
            if (pop) begin
                cur_op <= head.op;
                tl_r   <= {6'b0, head.tl[18:9], 7'b0, head.tl[8:0]};
                br_r   <= {6'b0, head.br[18:9], 7'b0, head.br[8:0]};
                arg_r  <= {20'b0, head.arg};
            end
            if (state == S_LOAD)                  ctrl_r <= {30'b0, 1'b1, cur_op};
            if (state == S_WAIT && bus.gp_finish) ctrl_r <= {30'b0, 1'b0, cur_op};
            if (state == S_REL)                   done_count <= done_count + 16'd1;
        end
    end

    assign bus.ctrl_out   = ctrl_r;
    assign bus.tl_out     = tl_r;
    assign bus.br_out     = br_r;
    assign bus.arg_out    = arg_r;
    assign bus.status_out = {done_count, 4'b0, overflow, busy, full, empty, 8'(count)};
endmodule

// File: tb/tb_gfx_cmd_queue.sv
// Self-checking bench for gfx_cmd_queue: directed vectors, corner sequences,
// and a random run against a queue-based reference model.
module tb_gfx_cmd_queue;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gfx_cmd_queue_if bus ();

    gfx_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] tl_w, br_w, arg_w;
        logic        op;
        logic [31:0] exp_tl, exp_br, exp_arg, exp_arm;
    } vec_t;

    typedef struct {
        bit          op;
        logic [31:0] tl, br, arg;
    } cmd_t;

    logic [31:0] ld_log[$];
    logic [31:0] ctl_log[$];
    bit          mon_en = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.tl_we)   ld_log.push_back(bus.arg_out);
            if (bus.ctrl_we) ctl_log.push_back(bus.ctrl_out);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic cpu_wr(input logic [1:0] s, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = s;
        bus.wr_data = d;
        cyc();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.wr_en     = 1'b0;
        bus.gp_finish = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // 0: load pulse, 1: arm pulse, 2: any ctrl pulse, 3: armed and waiting
    task automatic wait_sig(input int which, input string nm, output int waited);
        bit hit;
        hit    = 0;
        waited = 0;
        for (int i = 0; i < 60; i++) begin
            case (which)
                0:       hit = bus.tl_we;
                1:       hit = bus.ctrl_we && bus.ctrl_out[1];
                3:       hit = bus.ctrl_out[1] && !bus.ctrl_we;
                default: hit = bus.ctrl_we;
            endcase
            if (hit) break;
            cyc();
            waited++;
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=none expected=event", nm);
        end
    endtask

    function automatic logic [31:0] pack_pt(input logic [31:0] d);
        return d & 32'h03FF_01FF;
    endfunction

    initial begin
        vec_t        vecs[4];
        int          w, cnt;
        cmd_t        mq[$];
        cmd_t        cmd;
        logic [31:0] stg_tl, stg_br, stg_arg, e_tl, e_br, e_arg, e_ctrl;
        logic [15:0] done;
        bit          ovf, e_op, fin, popped, busy;
        int          ph, nph, pre;
        logic [3:0]  e_we;

        vecs[0] = '{32'h000A_0014, 32'h0031_0027, 32'h0000_0F00, 1'b0,
                    32'h000A_0014, 32'h0031_0027, 32'h0000_0F00, 32'd2};
        vecs[1] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'hABCD_E123, 1'b1,
                    32'h03FF_01FF, 32'h0234_0078, 32'h0000_0123, 32'd3};
        vecs[2] = '{32'h0000_0000, 32'h03FF_01FF, 32'h0000_0FFF, 1'b1,
                    32'h0000_0000, 32'h03FF_01FF, 32'h0000_0FFF, 32'd3};
        vecs[3] = '{32'hFC00_FE00, 32'h0155_00AA, 32'h0000_0555, 1'b0,
                    32'h0000_0000, 32'h0155_00AA, 32'h0000_0555, 32'd2};

        bus.wr_en = 0; bus.wr_sel = 0; bus.wr_data = 0; bus.gp_finish = 0;

        // reset and INIT disarm pulse
        do_reset();
        chk("init_ctrl_we", bus.ctrl_we, 1);
        chk("init_ctrl_out", bus.ctrl_out, 0);
        cyc();
        chk("idle_ctrl_we", bus.ctrl_we, 0);
        chk("idle_status", bus.status_out, 32'h0000_0100);

        // directed vectors
        for (int k = 0; k < 4; k++) begin
            cpu_wr(2'd0, vecs[k].tl_w);
            cpu_wr(2'd1, vecs[k].br_w);
            cpu_wr(2'd2, vecs[k].arg_w);
            cpu_wr(2'd3, 32'h7FFF_FFF0 | 32'(vecs[k].op));
            wait_sig(0, "vec_load", w);
            chk("vec_load_latency", w, 1);
            chk("vec_load_we", {bus.tl_we, bus.br_we, bus.arg_we}, 3'b111);
            chk("vec_tl", bus.tl_out, vecs[k].exp_tl);
            chk("vec_br", bus.br_out, vecs[k].exp_br);
            chk("vec_arg", bus.arg_out, vecs[k].exp_arg);
            cyc();
            chk("vec_arm_we", bus.ctrl_we, 1);
            chk("vec_arm_ctrl", bus.ctrl_out, vecs[k].exp_arm);
            cyc(); cyc();
            chk("vec_wait_quiet", bus.ctrl_we, 0);
            bus.gp_finish = 1'b1;
            cyc();
            bus.gp_finish = 1'b0;
            chk("vec_rel_we", bus.ctrl_we, 1);
            chk("vec_rel_ctrl", bus.ctrl_out, 32'(vecs[k].op));
            cyc();
            chk("vec_done", bus.status_out[31:16], k + 1);
        end

        // overflow: 1 popped, 16 queued, 1 dropped; then flush during WAIT
        do_reset(); cyc();
        cpu_wr(2'd0, 32'h0001_0002);
        cpu_wr(2'd1, 32'h0003_0004);
        cpu_wr(2'd2, 32'h0000_0ABC);
        for (int i = 0; i < 18; i++) cpu_wr(2'd3, (i == 0) ? 32'd1 : 32'd0);
        chk("ovf_status", bus.status_out, 32'h0000_0E10);
        chk("ovf_armed_draw", bus.ctrl_out, 32'd3);
        cpu_wr(2'd3, 32'h8000_0000);
        chk("flush_status", bus.status_out, 32'h0000_0500);
        bus.gp_finish = 1'b1;
        cyc();
        bus.gp_finish = 1'b0;
        chk("flush_rel_we", bus.ctrl_we, 1);
        chk("flush_rel_ctrl", bus.ctrl_out, 32'd1);
        cyc();
        chk("flush_idle_status", bus.status_out, 32'h0001_0100);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin cyc(); cnt += int'(bus.tl_we); end
        chk("flush_no_load", cnt, 0);

        // three commands in FIFO order, finish some cycles into each WAIT
        do_reset(); cyc();
        ld_log.delete(); ctl_log.delete();
        mon_en = 1;
        cpu_wr(2'd0, 32'h0005_0006);
        cpu_wr(2'd1, 32'h0007_0008);
        for (int i = 1; i <= 3; i++) begin
            cpu_wr(2'd2, 32'(i));
            cpu_wr(2'd3, 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            wait_sig(3, "seq_wait", w);
            repeat (4) cyc();
            bus.gp_finish = 1'b1;
            cyc();
            bus.gp_finish = 1'b0;
        end
        repeat (6) cyc();
        mon_en = 0;
        chk("seq_load_count", ld_log.size(), 3);
        chk("seq_ctrl_count", ctl_log.size(), 6);
        for (int i = 0; i < 3; i++) begin
            if (i < ld_log.size()) chk("seq_load_arg", ld_log[i], 32'(i + 1));
            if (2 * i + 1 < ctl_log.size()) begin
                chk("seq_arm", ctl_log[2 * i], 32'd2);
                chk("seq_rel", ctl_log[2 * i + 1], 32'd0);
            end
        end
        chk("seq_status", bus.status_out, 32'h0003_0100);

        // reset during WAIT with two queued
        do_reset(); cyc();
        for (int i = 0; i < 3; i++) cpu_wr(2'd3, 32'd0);
        wait_sig(3, "rst_wait", w);
        chk("rst_pre_count", bus.status_out[7:0], 2);
        rst = 1'b1;
        cyc();
        chk("rst_ctrl_we", bus.ctrl_we, 1);
        chk("rst_ctrl_out", bus.ctrl_out, 0);
        chk("rst_status", bus.status_out, 32'h0000_0500);
        rst = 1'b0;
        bus.gp_finish = 1'b1;
        cyc();
        chk("rst_idle_status", bus.status_out, 32'h0000_0100);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin cyc(); cnt += int'(bus.tl_we) + int'(bus.ctrl_we); end
        bus.gp_finish = 1'b0;
        chk("rst_no_pulses", cnt, 0);

        // random run against the reference model
        do_reset(); cyc();
        mq.delete();
        stg_tl = 0; stg_br = 0; stg_arg = 0;
        e_tl = 0; e_br = 0; e_arg = 0; e_ctrl = 0; e_op = 0;
        done = 0; ovf = 0; ph = 0;
        for (int it = 0; it < 3000; it++) begin
            bus.wr_en   = 1'($urandom % 2);
            bus.wr_sel  = 2'($urandom % 4);
            bus.wr_data = $urandom;
            if (bus.wr_sel == 2'd3 && ($urandom % 32) != 0) bus.wr_data[31] = 1'b0;
            fin = (it < 1500) ? (($urandom % 16) == 0) : (($urandom % 2) == 0);
            bus.gp_finish = fin;

            pre    = mq.size();
            popped = (ph == 0) && (pre > 0);
            if (popped) begin
                cmd   = mq.pop_front();
                e_tl  = cmd.tl; e_br = cmd.br; e_arg = cmd.arg; e_op = cmd.op;
            end
            case (ph)
                0:       nph = popped ? 1 : 0;
                1:       begin nph = 2; e_ctrl = {30'b0, 1'b1, e_op}; end
                2:       nph = 3;
                3:       begin nph = fin ? 4 : 3; if (fin) e_ctrl = {31'b0, e_op}; end
                default: begin nph = 0; done = done + 16'd1; end
            endcase
            if (bus.wr_en) begin
                case (bus.wr_sel)
                    2'd0: stg_tl  = pack_pt(bus.wr_data);
                    2'd1: stg_br  = pack_pt(bus.wr_data);
                    2'd2: stg_arg = bus.wr_data & 32'hFFF;
                    default:
                        if (bus.wr_data[31]) begin
                            mq.delete();
                            ovf = 0;
                        end else if (pre == DEPTH) ovf = 1;
                        else mq.push_back('{bus.wr_data[0], stg_tl, stg_br, stg_arg});
                endcase
            end
            ph = nph;

            cyc();
            busy = (ph != 0) || (mq.size() > 0);
            e_we = {(ph == 2 || ph == 4), {3{ph == 1}}};
            chk("rnd_status", bus.status_out,
                {done, 4'b0, ovf, busy, (mq.size() == DEPTH), (mq.size() == 0), 8'(mq.size())});
            chk("rnd_we", {bus.ctrl_we, bus.tl_we, bus.br_we, bus.arg_we}, e_we);
            chk("rnd_ctrl", bus.ctrl_out, e_ctrl);
            chk("rnd_tl", bus.tl_out, e_tl);
            chk("rnd_br", bus.br_out, e_br);
            chk("rnd_arg", bus.arg_out, e_arg);
        end
        bus.wr_en = 0;
        bus.gp_finish = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
